pwm_multi_channel: RTL and testbench

//   CH-channel PWM generator sharing one W-bit timebase. Programmable period and

---
 rtl/pwm_multi_channel_pkg.sv | 24 ++
 rtl/pwm_multi_channel_channel.sv | 64 ++++++
 rtl/pwm_multi_channel.sv | 119 +++++++++++
 tb/tb_pwm_multi_channel.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_multi_channel_pkg.sv
// ---------------------------------------------------------------------------
// pwm_multi_channel_pkg
//   Shared definitions for the multi-channel PWM generator: counting mode and
//   counter direction encodings, plus the helper that sizes the channel-select
//   port (at least one bit, even for a single channel).
// ---------------------------------------------------------------------------
package pwm_multi_channel_pkg;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Width of the channel index port: clog2(CH), never below one bit.
    function automatic int ch_idx_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/pwm_multi_channel_channel.sv
// ---------------------------------------------------------------------------
// pwm_multi_channel_channel
//   One PWM channel: pending (shadow) duty register, active duty register,
//   duty-vs-counter compare, live polarity inversion and registered output.
//
//   clk       in  1  clock, posedge
//   rst       in  1  synchronous reset, active-low
//   en        in  1  timebase running; when low the output rests at polarity
//   boundary  in  1  period boundary strobe from the timebase
//   wr_sel    in  1  write strobe already decoded for this channel
//   wr_duty   in  W  duty value to write
//   ctr       in  W  shared timebase counter
//   polarity  in  1  output inversion, applied live
//   pwm       out 1  registered PWM output
// ---------------------------------------------------------------------------
module pwm_multi_channel_channel #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         boundary,
    input  logic         wr_sel,
    input  logic [W-1:0] wr_duty,
    input  logic [W-1:0] ctr,
    input  logic         polarity,
    output logic         pwm
);

    logic [W-1:0] pending_reg;
    logic [W-1:0] pending_next;
    logic [W-1:0] active_reg;
    logic         pwm_reg;
    logic         raw;

    // The active register loads from pending_next rather than pending_reg so a
    // write landing in the boundary cycle is taken into the new period.
    always_comb begin
        pending_next = pending_reg;
        if (wr_sel) begin
            pending_next = wr_duty;
        end
    end

    // D=0 never exceeds ctr (always inactive); D>P always exceeds it.
    assign raw = (active_reg > ctr);

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_reg <= '0;
            active_reg  <= '0;
            pwm_reg     <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            if (boundary) begin
                active_reg <= pending_next;
            end
            pwm_reg <= en ? (raw ^ polarity) : polarity;
        end
    end

    assign pwm = pwm_reg;

endmodule

// File: rtl/pwm_multi_channel.sv
// ---------------------------------------------------------------------------
// pwm_multi_channel
//   CH-channel PWM generator on one shared W-bit timebase. Edge-aligned
//   (0..P, period P+1) or center-aligned (0..P..1, period 2P) counting.
//   Period, mode and duty are double-buffered and only take effect at a
//   period boundary (the posedge where the next counter value is 0).
//
//   clk          in  1   clock, posedge
//   rst          in  1   synchronous reset, active-low
//   en           in  1   1 = timebase runs, 0 = idle (counter held at 0)
//   center_mode  in  1   0 = edge-aligned, 1 = center-aligned (shadowed)
//   period       in  W   period value P (shadowed)
//   wr_en        in  1   duty write strobe
//   wr_ch        in  CW  channel index for the write (out of range ignored)
//   wr_duty      in  W   duty value D
//   polarity     in  CH  per-channel output inversion, live
//   pwm          out CH  registered PWM outputs
//   period_tick  out 1   registered pulse for each cycle with ctr==0 and en=1
// ---------------------------------------------------------------------------
module pwm_multi_channel
    import pwm_multi_channel_pkg::*;
#(
    parameter  int CH = 4,
    parameter  int W  = 8,
    localparam int CW = ch_idx_width(CH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          center_mode,
    input  logic [W-1:0]  period,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_ch,
    input  logic [W-1:0]  wr_duty,
    input  logic [CH-1:0] polarity,
    output logic [CH-1:0] pwm,
    output logic          period_tick
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] ctr_reg;
    logic [W-1:0] ctr_next;
    dir_e         dir_reg;
    dir_e         dir_next;
    logic [W-1:0] period_reg;
    mode_e        mode_reg;
    logic         tick_reg;
    logic         boundary;

    // Timebase. Idle, P==0 and the end of every period all fall through to
    // the default of ctr=0/up, which is what makes them boundaries.
    always_comb begin
        ctr_next = '0;
        dir_next = DIR_UP;
        if (en && (period_reg != '0)) begin
            if (mode_reg == MODE_EDGE) begin
                if (ctr_reg < period_reg) begin
                    ctr_next = ctr_reg + ONE;
                end
            end else if ((dir_reg == DIR_UP) && (ctr_reg < period_reg)) begin
                ctr_next = ctr_reg + ONE;
                dir_next = DIR_UP;
            end else if (ctr_reg > ONE) begin
                // Turning at the top or already descending. Reaching 1 on
                // the way down wraps straight to 0 (handled by the default),
                // so ctr==0 appears once per period and P=1 gives 0,1,0,1.
                ctr_next = ctr_reg - ONE;
                dir_next = DIR_DOWN;
            end
        end
    end

    assign boundary = (ctr_next == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctr_reg    <= '0;
            dir_reg    <= DIR_UP;
            period_reg <= '0;
            mode_reg   <= MODE_EDGE;
            tick_reg   <= 1'b0;
        end else begin
            ctr_reg  <= ctr_next;
            dir_reg  <= dir_next;
            tick_reg <= en && (ctr_reg == '0);
            if (boundary) begin
                period_reg <= period;
                mode_reg   <= mode_e'(center_mode);
            end
        end
    end

    assign period_tick = tick_reg;

    // Channel indices at or above CH match no slice, so those writes vanish.
    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic wr_sel;
            assign wr_sel = wr_en && (wr_ch == CW'(gi));

            pwm_multi_channel_channel #(
                .W(W)
            ) u_ch (
                .clk      (clk),
                .rst      (rst),
                .en       (en),
                .boundary (boundary),
                .wr_sel   (wr_sel),
                .wr_duty  (wr_duty),
                .ctr      (ctr_reg),
                .polarity (polarity[gi]),
                .pwm      (pwm[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pwm_multi_channel.sv
// ---------------------------------------------------------------------------
// tb_pwm_multi_channel
//   Directed bench for pwm_multi_channel (CH=3 so that wr_ch=3 is an
//   out-of-range index). A phase-based reference model predicts pwm and
//   period_tick each cycle; predictions go into a scoreboard queue when the
//   inputs are applied and are popped and compared after the clock edge.
// ---------------------------------------------------------------------------
module tb_pwm_multi_channel;

    localparam int CH = 3;
    localparam int W  = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          center_mode = 1'b0;
    logic [W-1:0]  period = '0;
    logic          wr_en = 1'b0;
    logic [CW-1:0] wr_ch = '0;
    logic [W-1:0]  wr_duty = '0;
    logic [CH-1:0] polarity = '0;
    logic [CH-1:0] pwm;
    logic          period_tick;

    always #5 clk = ~clk;

    pwm_multi_channel #(
        .CH(CH),
        .W (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .center_mode (center_mode),
        .period      (period),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_duty     (wr_duty),
        .polarity    (polarity),
        .pwm         (pwm),
        .period_tick (period_tick)
    );

    typedef struct packed {
        logic [CH-1:0] pwm;
        logic          tick;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: position k within the period, period length derived
    // from the active P and mode.
    int   m_k = 0;
    int   m_p = 0;
    logic m_mode = 1'b0;
    int   m_pend[CH];
    int   m_act[CH];

    // Measurements over a window.
    int cyc_no = 0;
    int last_tick = -1;
    int gaps[$];
    int hi0 = 0;
    int hi_any = 0;

    function automatic int m_len();
        if (m_p == 0) return 1;
        return m_mode ? 2 * m_p : m_p + 1;
    endfunction

    task automatic model_step(output exp_t e);
        int ctr;
        int len;
        e = '0;
        if (!rst) begin
            m_k = 0;
            m_p = 0;
            m_mode = 1'b0;
            for (int i = 0; i < CH; i++) begin
                m_pend[i] = 0;
                m_act[i] = 0;
            end
            return;
        end
        ctr = (m_mode && (m_k > m_p)) ? (2 * m_p - m_k) : m_k;
        for (int i = 0; i < CH; i++) begin
            e.pwm[i] = en ? (logic'(m_act[i] > ctr) ^ polarity[i]) : polarity[i];
        end
        e.tick = en && (ctr == 0);
        if (wr_en && (int'(wr_ch) < CH)) m_pend[int'(wr_ch)] = int'(wr_duty);
        len = m_len();
        m_k = en ? ((m_k + 1 >= len) ? 0 : m_k + 1) : 0;
        if (m_k == 0) begin
            m_p = int'(period);
            m_mode = center_mode;
            for (int i = 0; i < CH; i++) m_act[i] = m_pend[i];
        end
    endtask

    task automatic cyc(input int n, input string tag);
        exp_t e;
        exp_t want;
        for (int c = 0; c < n; c++) begin
            model_step(e);
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            want = sb_q.pop_front();
            n_cmp++;
            assert (pwm === want.pwm) else begin
                n_bad++;
                $error("FAIL %s pwm: got %b want %b (cycle %0d)", tag, pwm, want.pwm, cyc_no);
            end
            n_cmp++;
            assert (period_tick === want.tick) else begin
                n_bad++;
                $error("FAIL %s tick: got %b want %b (cycle %0d)", tag, period_tick, want.tick, cyc_no);
            end
            cyc_no++;
            if (pwm[0] === 1'b1) hi0++;
            if (|pwm) hi_any++;
            if (period_tick === 1'b1) begin
                if (last_tick >= 0) gaps.push_back(cyc_no - last_tick);
                last_tick = cyc_no;
            end
        end
        $display("step %-16s cycles=%0d pwm=%b tick=%b", tag, n, pwm, period_tick);
    endtask

    task automatic clear_meas();
        hi0 = 0;
        hi_any = 0;
        last_tick = -1;
        gaps.delete();
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        n_cmp++;
        assert (got == want) else begin
            n_bad++;
            $error("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic wr(input int ch, input int d);
        wr_en = 1'b1;
        wr_ch = CW'(ch);
        wr_duty = W'(d);
        cyc(1, "write");
        wr_en = 1'b0;
    endtask

    // Advance until the model sits at phase k (bounded).
    task automatic align(input int k, input string tag);
        for (int g = 0; g < 64 && m_k != k; g++) cyc(1, "align");
        check_int(tag, m_k, k);
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        cyc(3, "reset");
        rst = 1'b1;

        // 1: edge, P=9, D={3,0,10}
        period = W'(9);
        center_mode = 1'b0;
        wr(0, 3);
        wr(1, 0);
        wr(2, 10);
        en = 1'b1;
        cyc(12, "t1 warm");
        clear_meas();
        cyc(30, "t1 edge P9");
        check_int("t1 ch0 highs/30", hi0, 9);
        check_int("t1 gap count", gaps.size(), 2);
        if (gaps.size() > 0) check_int("t1 tick gap", gaps[0], 10);

        // 2: center, P=4, D0=2, then inverted polarity
        center_mode = 1'b1;
        period = W'(4);
        wr(0, 2);
        cyc(20, "t2 warm");
        clear_meas();
        cyc(16, "t2 center P4");
        if (gaps.size() > 0) check_int("t2 tick gap", gaps[0], 8);
        else check_int("t2 gap count", gaps.size(), 1);
        polarity = 3'b001;
        cyc(16, "t2 inverted");
        polarity = 3'b000;

        // 3: mid-period and boundary-cycle duty writes
        center_mode = 1'b0;
        period = W'(9);
        wr(0, 3);
        cyc(25, "t3 warm");
        align(4, "t3 align mid");
        wr(0, 7);
        clear_meas();
        cyc(5, "t3 old duty");
        check_int("t3 old duty tail", hi0, 0);
        clear_meas();
        cyc(10, "t3 new duty");
        check_int("t3 new duty highs", hi0, 7);
        align(9, "t3 align end");
        wr(0, 2);
        clear_meas();
        cyc(10, "t3 boundary wr");
        check_int("t3 boundary wr highs", hi0, 2);

        // 4: idle for 20 cycles, then restart
        polarity = 3'b101;
        en = 1'b0;
        cyc(20, "t4 idle");
        en = 1'b1;
        cyc(1, "t4 restart");
        check_int("t4 first tick", int'(period_tick), 1);
        cyc(20, "t4 run");
        polarity = 3'b000;

        // 5: P=0 and a mid-period period change
        period = '0;
        wr(0, 1);
        cyc(15, "t5 warm");
        clear_meas();
        cyc(10, "t5 P0");
        check_int("t5 P0 ticks", gaps.size(), 9);
        check_int("t5 P0 ch0 highs", hi0, 10);
        period = W'(9);
        cyc(12, "t5 P9 warm");
        align(0, "t5 align start");
        clear_meas();
        cyc(3, "t5 P9 head");
        period = W'(4);
        cyc(25, "t5 P9 to P4");
        check_int("t5 gap count", (gaps.size() >= 2) ? 1 : 0, 1);
        if (gaps.size() >= 2) begin
            check_int("t5 old period", gaps[0], 10);
            check_int("t5 new period", gaps[1], 5);
        end

        // 6: reset mid-period with an invalid write, then invalid write live
        period = W'(9);
        wr(0, 3);
        cyc(25, "t6 warm");
        align(5, "t6 align");
        rst = 1'b0;
        wr(3, 5);
        rst = 1'b1;
        cyc(3, "t6 after rst");
        wr(3, 5);
        clear_meas();
        cyc(25, "t6 invalid wr");
        check_int("t6 no channel active", hi_any, 0);
        wr(1, 4);
        clear_meas();
        cyc(20, "t6 valid wr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
